imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time instruction-memory loader that feeds the CPU its program. It receives a framed byte stream over a valid/ready handshake, assembles 16-bit instruction words, writes them to instruction memory, and verifies an XOR checksum. It then raises `cpu_enable` to release the CPU pipeline. It sits between the host link and the CPU top, and is the writer side of the instruction memory that the datapath fetches from.

## Interface
Parameters:
- `ADDR_W`, 8: instruction-memory address width; capacity is 2^ADDR_W words.
- `DATA_W`, 16: instruction word width. Fixed at 16; the frame format depends on it.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx_valid`  in  1  host byte valid.
- `rx_data`  in  8  host byte.
- `rx_ready`  out  1  loader can accept a byte.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_addr`  out  ADDR_W  write address (word index).
- `imem_wdata`  out  DATA_W  write data, {hi byte, lo byte}.
- `cpu_enable`  out  1  CPU run enable.
- `load_done`  out  1  program loaded and verified.
- `load_err`  out  1  frame rejected.

## Operation
- Frame, all fields MSB byte first: SYNC (0xA5), LEN (16-bit word count N), N data words, CSUM (16-bit XOR of all data words).
- A byte transfers only on a cycle where `rx_valid` and `rx_ready` are both high.
- FSM states: WAIT_SYNC, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM_HI, CSUM_LO, RUN, ERROR.
- WAIT_SYNC: 0xA5 moves to LEN_HI. Any other byte is discarded and the state holds.
- LEN_LO accepted:
  - if N == 0, go to CSUM_HI;
  - if N > 2^ADDR_W, go to ERROR;
  - otherwise clear the word counter and running XOR, then go to DATA_HI.
- DATA_HI latches the high byte.
- DATA_LO forms the word, issues the write, XORs the word into the running checksum, and increments the counter. It returns to DATA_HI until the counter equals N, then goes to CSUM_HI.
- CSUM_LO: if the received CSUM equals the running XOR, go to RUN; otherwise go to ERROR.
- RUN: `rx_ready`=0, `cpu_enable`=1, `load_done`=1. RUN is terminal until reset.
- ERROR:
  - `load_err`=1, `cpu_enable`=0, `rx_ready`=1.
  - 0xA5 clears `load_err` and goes to LEN_HI (retry).
  - Other bytes are discarded.
  - Memory contents from the failed frame are not erased.
- The counter is ADDR_W+1 bits wide, so that N = 2^ADDR_W terminates correctly. `imem_addr` is counter[ADDR_W-1:0].

## Timing
- Reset values: state WAIT_SYNC, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_enable`=0, `load_done`=0, `load_err`=0.
- `rx_ready` is decoded combinationally from state. It is 1 in every state except RUN, so it is 1 immediately after reset deasserts.
- One byte can be accepted per cycle. There are no bubbles: back-to-back valid bytes are all accepted.
- Write latency: `imem_we`, `imem_addr` and `imem_wdata` are registered. They are valid for exactly one cycle, starting the cycle after the DATA_LO handshake.
- `cpu_enable`, `load_done` and `load_err` are registered. They change the cycle after the CSUM_LO handshake, or after the LEN_LO handshake for the oversize error.
- The last data write and `cpu_enable` never coincide. At least two CSUM byte cycles separate them.
- `rx_valid` low: the state holds and no write occurs. Gaps of any length are legal in any state.
- Reset mid-frame: immediate return to reset values. A write strobe in flight is dropped.

## Structure
- Shared package `imem_loader_pkg` holds:
  - the state enum `loader_state_t`;
  - constants `SYNC_BYTE` = 8'hA5, `LEN_W` = 16 and `INSTR_W` = 16;
  - the opcode field position [15:12], shared with the control unit decode.
- The block is a single module with no sub-module. The byte assembly and FSM are too tightly coupled to split.

## Test plan
- Stream A5 00 02 12 34 AB CD B9 F9 with `rx_valid` continuously high:
  - writes (0, 0x1234) and (1, 0xABCD), each strobe one cycle;
  - `cpu_enable` and `load_done` go to 1 the cycle after the final byte;
  - `rx_ready` goes to 0.
- Same frame with CSUM 00 00:
  - both writes occur;
  - `load_err`=1 and `cpu_enable` stays 0;
  - then send A5 00 01 00 07 00 07: `load_err` clears, address 0 is rewritten with 0x0007, and `cpu_enable`=1.
- Garbage bytes 00 FF 5A before A5 00 00 00 00: the garbage is ignored, there are no writes, and `cpu_enable`=1.
- With ADDR_W=8, LEN 0x0101 gives `load_err`=1 the cycle after LEN_LO and no writes.
- With ADDR_W=4, a full 16-word frame writes addresses 0..15 with no wrap and ends in RUN.
- Random `rx_valid` gaps, and an asynchronous reset asserted mid-DATA_LO: all outputs return to reset values the same cycle, `imem_we` is not asserted, and the next frame loads correctly.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: loader FSM states, frame constants and instruction field positions
package imem_loader_pkg;
  typedef enum logic [3:0] {
    WAIT_SYNC, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM_HI, CSUM_LO, RUN, ERROR
  } loader_state_t;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int LEN_W = 16;
  localparam int INSTR_W = 16;
  localparam int OPCODE_HI = 15;
  localparam int OPCODE_LO = 12;
  function automatic logic [OPCODE_HI-OPCODE_LO:0] opcode(input logic [INSTR_W-1:0] w);
    return w[OPCODE_HI:OPCODE_LO];
  endfunction
endpackage

// File: rtl/imem_loader.sv
// imem_loader: framed byte stream -> instruction memory writes, XOR-verified, then CPU release
//   clk, reset (async active-low)
//   rx_valid/rx_data/rx_ready : host byte handshake
//   imem_we/imem_addr/imem_wdata : registered one-cycle word write
//   cpu_enable/load_done/load_err : registered load status
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_enable,
  output logic              load_done,
  output logic              load_err
);
  localparam logic [LEN_W:0] CAP = (LEN_W+1)'(2**ADDR_W);
  loader_state_t state_q, state_d;
  logic [ADDR_W:0] cnt_q, cnt_d, cnt_inc;
  logic [LEN_W-1:0] len_q, len_d, len_n;
  logic [7:0] hi_q, hi_d;
  logic [INSTR_W-1:0] csum_q, csum_d, word;
  logic we_q, we_d, en_q, en_d, done_q, done_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic acc;
  assign rx_ready = state_q != RUN;
  assign acc = rx_valid && rx_ready;
  assign cnt_inc = cnt_q + 1'b1;
  assign len_n = {len_q[LEN_W-1:8], rx_data};
  // hi_q holds the high byte of either a data word or the received checksum
  assign word = {hi_q, rx_data};
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    len_d = len_q;
    hi_d = hi_q;
    csum_d = csum_q;
    we_d = 1'b0;
    addr_d = addr_q;
    wdata_d = wdata_q;
    en_d = en_q;
    done_d = done_q;
    err_d = err_q;
    if (acc) begin
      case (state_q)
        WAIT_SYNC: state_d = rx_data == SYNC_BYTE ? LEN_HI : WAIT_SYNC;
        LEN_HI: begin
          len_d = {rx_data, 8'h00};
          state_d = LEN_LO;
        end
        LEN_LO: begin
          len_d = len_n;
          if ({1'b0, len_n} > CAP) begin
            err_d = 1'b1;
            state_d = ERROR;
          end else begin
            cnt_d = '0;
            csum_d = '0;
            state_d = len_n == '0 ? CSUM_HI : DATA_HI;
          end
        end
        DATA_HI: begin
          hi_d = rx_data;
          state_d = DATA_LO;
        end
        DATA_LO: begin
          we_d = 1'b1;
          addr_d = cnt_q[ADDR_W-1:0];
          wdata_d = word;
          csum_d = csum_q ^ word;
          cnt_d = cnt_inc;
          // counter is one bit wider than the address so N = 2^ADDR_W terminates
          state_d = LEN_W'(cnt_inc) == len_q ? CSUM_HI : DATA_HI;
        end
        CSUM_HI: begin
          hi_d = rx_data;
          state_d = CSUM_LO;
        end
        CSUM_LO: begin
          en_d = word == csum_q;
          done_d = word == csum_q;
          err_d = word != csum_q;
          state_d = word == csum_q ? RUN : ERROR;
        end
        ERROR: begin
          err_d = rx_data != SYNC_BYTE;
          state_d = rx_data == SYNC_BYTE ? LEN_HI : ERROR;
        end
        default: state_d = state_q;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= WAIT_SYNC;
      cnt_q <= '0;
      len_q <= '0;
      hi_q <= '0;
      csum_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      en_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      hi_q <= hi_d;
      csum_q <= csum_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      en_q <= en_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  assign imem_we = we_q;
  assign imem_addr = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_enable = en_q;
  assign load_done = done_q;
  assign load_err = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized frame stimulus against a word-list reference model
module tb_imem_loader;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rx_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic sel = 1'b0;
  logic rdy8, we8, en8, done8, err8;
  logic [7:0] addr8;
  logic [15:0] wd8;
  logic rdy4, we4, en4, done4, err4;
  logic [3:0] addr4;
  logic [15:0] wd4;
  logic o_rdy, o_we, o_en, o_done, o_err;
  logic [7:0] o_addr;
  logic [15:0] o_wd;
  always #5 clk = ~clk;
  imem_loader #(.ADDR_W(8)) u8 (
    .clk(clk), .reset(reset), .rx_valid(rx_valid & ~sel), .rx_data(rx_data), .rx_ready(rdy8),
    .imem_we(we8), .imem_addr(addr8), .imem_wdata(wd8),
    .cpu_enable(en8), .load_done(done8), .load_err(err8)
  );
  imem_loader #(.ADDR_W(4)) u4 (
    .clk(clk), .reset(reset), .rx_valid(rx_valid & sel), .rx_data(rx_data), .rx_ready(rdy4),
    .imem_we(we4), .imem_addr(addr4), .imem_wdata(wd4),
    .cpu_enable(en4), .load_done(done4), .load_err(err4)
  );
  assign o_rdy = sel ? rdy4 : rdy8;
  assign o_we = sel ? we4 : we8;
  assign o_addr = sel ? {4'h0, addr4} : addr8;
  assign o_wd = sel ? wd4 : wd8;
  assign o_en = sel ? en4 : en8;
  assign o_done = sel ? done4 : done8;
  assign o_err = sel ? err4 : err8;
  int checks = 0, errors = 0, gap_max = 0;
  logic [7:0] fq[$];
  logic [15:0] exp_w[$];
  int wa[$];
  logic [15:0] wdq[$];
  always @(negedge clk) if (o_we) begin
    wa.push_back(int'(o_addr));
    wdq.push_back(o_wd);
  end
  task automatic send(input logic [7:0] b);
    int n = gap_max > 0 ? $urandom_range(gap_max, 0) : 0;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
    rx_valid = 1'b1;
    rx_data = b;
    checks++;
    if (o_rdy !== 1'b1) begin
      errors++;
      $display("FAIL rx_ready byte %h got %b want 1", b, o_rdy);
    end
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask
  task automatic send_all;
    foreach (fq[i]) send(fq[i]);
  endtask
  task automatic build(input bit good);
    logic [15:0] x = '0;
    int n = exp_w.size();
    fq.delete();
    fq.push_back(8'hA5);
    fq.push_back(8'(n >> 8));
    fq.push_back(8'(n));
    foreach (exp_w[i]) begin
      fq.push_back(exp_w[i][15:8]);
      fq.push_back(exp_w[i][7:0]);
      x ^= exp_w[i];
    end
    if (!good) x ^= 16'(1 << $urandom_range(15, 0));
    fq.push_back(x[15:8]);
    fq.push_back(x[7:0]);
  endtask
  task automatic rand_words(input int n);
    exp_w.delete();
    repeat (n) exp_w.push_back(16'($urandom));
  endtask
  task automatic do_reset;
    @(negedge clk);
    rx_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    wa.delete();
    wdq.delete();
  endtask
  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      checks++;
      if ({o_we, o_addr, o_wd, o_en, o_done, o_err} !== 28'h0) begin
        errors++;
        $display("FAIL reset_state dut%0d got %h want 0", s, {o_we, o_addr, o_wd, o_en, o_done, o_err});
      end
    end
    sel = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (o_rdy !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got %b want 1", o_rdy);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_basic;
    int bad;
    sel = 1'b0;
    do_reset();
    exp_w = {16'h1234, 16'hABCD};
    fq = {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hB9, 8'hF9};
    foreach (fq[i]) begin
      send(fq[i]);
      if (i == 4) begin
        checks++;
        if ({o_we, o_addr, o_wd} !== {1'b1, 8'h00, 16'h1234}) begin
          errors++;
          $display("FAIL basic_write0 got %b/%h/%h want 1/00/1234", o_we, o_addr, o_wd);
        end
      end
      if (i == 5 || i == 7) begin
        checks++;
        if ({o_we, o_en} !== 2'b00) begin
          errors++;
          $display("FAIL basic_idle%0d got we=%b en=%b want 0 0", i, o_we, o_en);
        end
      end
      if (i == 6) begin
        checks++;
        if ({o_we, o_addr, o_wd} !== {1'b1, 8'h01, 16'hABCD}) begin
          errors++;
          $display("FAIL basic_write1 got %b/%h/%h want 1/01/abcd", o_we, o_addr, o_wd);
        end
      end
    end
    checks++;
    if ({o_en, o_done, o_err, o_rdy} !== 4'b1100) begin
      errors++;
      $display("FAIL basic_run got %b want 1100", {o_en, o_done, o_err, o_rdy});
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    bad = wa.size() != exp_w.size() || o_en !== 1'b1;
    foreach (exp_w[i]) if (!bad && (wa[i] != i || wdq[i] !== exp_w[i])) bad = 1;
    if (bad) begin
      errors++;
      $display("FAIL basic_writes got %0d writes en=%b want %0d en=1", wa.size(), o_en, exp_w.size());
    end
  endtask
  task automatic test_bad_csum;
    int bad;
    sel = 1'b0;
    do_reset();
    exp_w = {16'h1234, 16'hABCD};
    fq = {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h00};
    send_all();
    checks++;
    if ({o_en, o_done, o_err, o_rdy} !== 4'b0011) begin
      errors++;
      $display("FAIL badcsum_status got %b want 0011", {o_en, o_done, o_err, o_rdy});
    end
    checks++;
    bad = wa.size() != exp_w.size();
    foreach (exp_w[i]) if (!bad && (wa[i] != i || wdq[i] !== exp_w[i])) bad = 1;
    if (bad) begin
      errors++;
      $display("FAIL badcsum_writes got %0d writes want %0d", wa.size(), exp_w.size());
    end
    wa.delete();
    wdq.delete();
    exp_w = {16'h0007};
    fq = {8'hA5, 8'h00, 8'h01, 8'h00, 8'h07, 8'h00, 8'h07};
    send(fq[0]);
    checks++;
    if (o_err !== 1'b0) begin
      errors++;
      $display("FAIL retry_err_clear got %b want 0", o_err);
    end
    for (int i = 1; i < fq.size(); i++) send(fq[i]);
    checks++;
    if ({o_en, o_done, o_err} !== 3'b110) begin
      errors++;
      $display("FAIL retry_run got %b want 110", {o_en, o_done, o_err});
    end
    checks++;
    bad = wa.size() != exp_w.size();
    foreach (exp_w[i]) if (!bad && (wa[i] != i || wdq[i] !== exp_w[i])) bad = 1;
    if (bad) begin
      errors++;
      $display("FAIL retry_writes got %0d writes want %0d", wa.size(), exp_w.size());
    end
  endtask
  task automatic test_garbage;
    sel = 1'b0;
    do_reset();
    fq = {8'h00, 8'hFF, 8'h5A};
    send_all();
    checks++;
    if ({o_en, o_err} !== 2'b00) begin
      errors++;
      $display("FAIL garbage_ignored got %b want 00", {o_en, o_err});
    end
    fq = {8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
    send_all();
    checks++;
    if ({o_en, o_done, o_err, wa.size() == 0} !== 4'b1101) begin
      errors++;
      $display("FAIL garbage_run got %b writes=%0d want 110 writes=0", {o_en, o_done, o_err}, wa.size());
    end
  endtask
  task automatic test_oversize;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      do_reset();
      fq = s == 0 ? {8'hA5, 8'h01, 8'h01} : {8'hA5, 8'h00, 8'h11};
      send_all();
      checks++;
      if ({o_en, o_done, o_err} !== 3'b001) begin
        errors++;
        $display("FAIL oversize%0d got %b want 001", s, {o_en, o_done, o_err});
      end
      fq = {8'h00, 8'h00, 8'h00, 8'h00};
      send_all();
      checks++;
      if ({o_err, wa.size() == 0} !== 2'b11) begin
        errors++;
        $display("FAIL oversize%0d_nowrite got err=%b writes=%0d want 1 0", s, o_err, wa.size());
      end
    end
  endtask
  task automatic test_full;
    int bad;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      do_reset();
      rand_words(s == 0 ? 256 : 16);
      build(1'b1);
      send_all();
      checks++;
      bad = wa.size() != exp_w.size() || {o_en, o_done, o_err} !== 3'b110;
      foreach (exp_w[i]) if (!bad && (wa[i] != i || wdq[i] !== exp_w[i])) bad = 1;
      if (bad) begin
        errors++;
        $display("FAIL full%0d got %0d writes status %b want %0d 110", s, wa.size(), {o_en, o_done, o_err}, exp_w.size());
      end
    end
  endtask
  task automatic test_random;
    int bad;
    bit good;
    gap_max = 3;
    for (int k = 0; k < 8; k++) begin
      sel = 1'($urandom_range(1, 0));
      good = 1'($urandom_range(1, 0));
      do_reset();
      rand_words($urandom_range(12, 1));
      build(good);
      send_all();
      checks++;
      bad = wa.size() != exp_w.size() || {o_en, o_done, o_err, o_rdy} !== (good ? 4'b1100 : 4'b0011);
      foreach (exp_w[i]) if (!bad && (wa[i] != i || wdq[i] !== exp_w[i])) bad = 1;
      if (bad) begin
        errors++;
        $display("FAIL random%0d good=%0d got %0d writes status %b want %0d", k, good, wa.size(), {o_en, o_done, o_err, o_rdy}, exp_w.size());
      end
    end
    gap_max = 0;
  endtask
  task automatic test_reset_mid;
    int bad;
    sel = 1'b0;
    do_reset();
    rand_words(3);
    build(1'b1);
    for (int i = 0; i < 7; i++) send(fq[i]);
    checks++;
    if ({o_we, o_addr} !== {1'b1, 8'h01}) begin
      errors++;
      $display("FAIL midreset_strobe got %b/%h want 1/01", o_we, o_addr);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({o_we, o_addr, o_wd, o_en, o_done, o_err, o_rdy} !== 29'h1) begin
      errors++;
      $display("FAIL midreset_outputs got %h want 1", {o_we, o_addr, o_wd, o_en, o_done, o_err, o_rdy});
    end
    @(negedge clk);
    checks++;
    if (wa.size() != 1) begin
      errors++;
      $display("FAIL midreset_dropped got %0d writes want 1", wa.size());
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    wa.delete();
    wdq.delete();
    gap_max = 2;
    rand_words(5);
    build(1'b1);
    send_all();
    gap_max = 0;
    checks++;
    bad = wa.size() != exp_w.size() || {o_en, o_done, o_err} !== 3'b110;
    foreach (exp_w[i]) if (!bad && (wa[i] != i || wdq[i] !== exp_w[i])) bad = 1;
    if (bad) begin
      errors++;
      $display("FAIL midreset_reload got %0d writes status %b want %0d 110", wa.size(), {o_en, o_done, o_err}, exp_w.size());
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_bad_csum();
    test_garbage();
    test_oversize();
    test_full();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
